// File: rtl/simple_system_f2sdram_rsp_timing_adt.sv
// Avalon-ST timing adapter for the f2sdram response stream: converts an upstream
// readyLatency=READY_LATENCY source to a readyLatency=0 sink via a credit-gated FIFO.
module simple_system_f2sdram_rsp_timing_adt #(
    parameter int DATA_WIDTH    = 8,
    parameter int READY_LATENCY = 2,
    parameter int DEPTH         = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int            AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT     = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] CREDIT_LIMIT = (AW+2)'(DEPTH);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic [READY_LATENCY-1:0] cr;
    logic                     in_reset;
    logic                     overflow_q;

    logic permit;
    logic full;
    logic push;
    logic pop;
    logic drop;

    function automatic logic [AW+1:0] credits_in_flight(input logic [READY_LATENCY-1:0] v);
        logic [AW+1:0] n;
        n = '0;
        for (int i = 0; i < READY_LATENCY; i++) begin
            n = n + (AW+2)'(v[i]);
        end
        return n;
    endfunction

    // Beats already granted but not yet arrived are reserved against free space,
    // so a beat that lands on its permit always finds room.
    assign in_ready  = ~in_reset & (((AW+2)'(count) + credits_in_flight(cr)) < CREDIT_LIMIT);

    assign permit    = cr[READY_LATENCY-1];
    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & permit & (~full | pop);
    assign drop      = in_valid & ~push;
    assign overflow  = overflow_q;
    assign out_data  = mem[rd_ptr];

    // Credit pipeline: cr[READY_LATENCY-1] is the grant issued READY_LATENCY cycles ago
    generate
        if (READY_LATENCY == 1) begin : g_cr_single
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cr <= '0;
                end else begin
                    cr <= in_ready;
                end
            end
        end else begin : g_cr_shift
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cr <= '0;
                end else begin
                    cr <= {cr[READY_LATENCY-2:0], in_ready};
                end
            end
        end
    endgenerate

    // FIFO control state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_reset   <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            in_reset <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage: payload only, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_simple_system_f2sdram_rsp_timing_adt.sv
// Randomized bench for the f2sdram response timing adapter with a queue-based reference model.
module tb_simple_system_f2sdram_rsp_timing_adt;

    localparam int DW    = 8;
    localparam int RL    = 2;
    localparam int DEPTH = 8;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          overflow;

    always #5 clk = ~clk;

    simple_system_f2sdram_rsp_timing_adt #(
        .DATA_WIDTH    (DW),
        .READY_LATENCY (RL),
        .DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: buffered beats, history of grants (index 0 newest), sticky flag
    logic [DW-1:0] q[$];
    logic [DW-1:0] popped[$];
    int            pop_cycle[$];
    bit            hist[RL];
    bit            m_in_reset = 1'b1;
    bit            m_ovf      = 1'b0;
    int            cyc        = 0;
    int            n_push     = 0;
    int            max_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        int pending = 0;
        foreach (hist[i]) pending += int'(hist[i]);
        return !m_in_reset && ((q.size() + pending) < DEPTH);
    endfunction

    task automatic model_step();
        bit ir;
        bit permit;
        bit pop;
        bit push;
        ir     = m_in_ready();
        permit = hist[RL-1];
        pop    = (q.size() != 0) && out_ready;
        push   = in_valid && permit && ((q.size() < DEPTH) || pop);
        if (in_valid && !push) m_ovf = 1'b1;
        if (pop) begin
            popped.push_back(q.pop_front());
            pop_cycle.push_back(cyc);
        end
        if (push) begin
            q.push_back(in_data);
            n_push++;
        end
        for (int i = RL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0]    = ir;
        m_in_reset = 1'b0;
        if (q.size() > max_cnt) max_cnt = q.size();
        cyc++;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            foreach (hist[i]) hist[i] = 1'b0;
            m_in_reset = 1'b1;
            m_ovf      = 1'b0;
        end else begin
            model_step();
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    end

    // Offer n beats, one on every cycle the upstream protocol permits
    task automatic send(input int n, input logic [DW-1:0] base, input bit rnd_data, input bit rnd_ready);
        int            sent  = 0;
        int            guard = 0;
        logic [DW-1:0] d;
        while (sent < n && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (hist[RL-1]) begin
                if (rnd_data) begin
                    d = DW'($urandom);
                    if (d == 8'hA5) d = 8'h5A;
                end else begin
                    d = base + DW'(sent);
                end
                in_valid = 1'b1;
                in_data  = d;
                sent++;
            end else begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("send_progress", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int g = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int bad;
        int g;
        bit seen_a5;

        // Test 1: reset with in_valid asserted
        in_valid = 1'b1;
        in_data  = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // Test 2: streaming 0x00..0x3F at full rate
        out_ready = 1'b1;
        mark = popped.size();
        send(64, 8'h00, 1'b0, 1'b0);
        drain();
        chk("stream_count", 32'(popped.size() - mark), 32'd64);
        bad = 0;
        for (int i = 0; i < 64 && (mark + i) < popped.size(); i++)
            if (popped[mark+i] != DW'(i)) bad++;
        chk("stream_order", 32'(bad), 32'd0);
        if (popped.size() >= mark + 64)
            chk("stream_rate", 32'(pop_cycle[mark+63] - pop_cycle[mark]), 32'd63);
        chk("stream_overflow", 32'(overflow), 32'd0);

        // Test 3: backpressure fills exactly DEPTH entries
        out_ready = 1'b0;
        mark = popped.size();
        send(8, 8'h40, 1'b0, 1'b0);
        chk("bp_model_count", 32'(q.size()), 32'd8);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);

        // Test 4: beat without a permit is dropped and flagged
        g = 0;
        while (hist[RL-1] && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        drain();
        chk("bp_drained", 32'(popped.size() - mark), 32'd8);
        bad = 0;
        for (int i = 0; i < 8 && (mark + i) < popped.size(); i++)
            if (popped[mark+i] != DW'(8'h40 + i)) bad++;
        chk("bp_order", 32'(bad), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Test 5: 100 random beats with random downstream ready
        mark = n_push;
        send(100, 8'h00, 1'b1, 1'b1);
        drain();
        chk("wrap_push_count", 32'(n_push - mark), 32'd100);
        chk("max_count_le_depth", 32'(max_cnt <= DEPTH), 32'd1);
        seen_a5 = 1'b0;
        foreach (popped[i]) if (popped[i] == 8'hA5) seen_a5 = 1'b1;
        chk("a5_never_out", 32'(seen_a5), 32'd0);
        chk("ovf_still_sticky", 32'(overflow), 32'd1);

        // Test 6: asynchronous reset with five beats buffered
        out_ready = 1'b0;
        send(5, 8'h60, 1'b0, 1'b0);
        chk("mid_model_count", 32'(q.size()), 32'd5);
        chk("mid_out_valid_before", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chk("async_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        mark = popped.size();
        send(3, 8'h11, 1'b0, 1'b0);
        drain();
        chk("post_reset_count", 32'(popped.size() - mark), 32'd3);
        if (popped.size() > mark)
            chk("first_after_reset", 32'(popped[mark]), 32'h11);
        chk("post_reset_overflow", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
